// File: rtl/product_accumulator_pkg.sv
// Shared defaults and FSM state encoding for the product accumulator stage.
package product_accumulator_pkg;

  localparam int PROD_W_DEF    = 17;
  localparam int ACC_W_DEF     = 24;
  localparam int MAX_TERMS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Combinational unsigned add that clamps to all-ones on carry-out; ovf flags the clamp.
module sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[W];
  assign sum  = ovf ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums a frame of unsigned products into one saturating sum; result registered 1 cycle after the closing accept.
// in_ready drops while the result is held; it returns the cycle after out_ready is taken (1-cycle bubble).
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter  int PROD_W    = PROD_W_DEF,
  parameter  int ACC_W     = ACC_W_DEF,
  parameter  int MAX_TERMS = MAX_TERMS_DEF,
  localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_count
);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               sat;
  logic               sat_nxt;
  logic               ovf;
  logic               accept;
  logic               closing;

  assign in_ready = (state != HOLD);
  assign accept   = in_valid & in_ready;
  assign cnt_nxt  = cnt + CNT_W'(1);
  assign sat_nxt  = sat | ovf;
  // The term limit closes the frame even when the producer never marks a last product.
  assign closing  = in_last | (cnt_nxt == CNT_W'(MAX_TERMS));

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (ACC_W'(in_prod)),
    .sum (acc_nxt),
    .ovf (ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
      out_count <= '0;
    end else if (flush) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            sat <= sat_nxt;
            if (closing) begin
              out_sum   <= acc_nxt;
              out_sat   <= sat_nxt;
              out_count <= cnt_nxt;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Two accumulator instances (narrow sum / short frame) share stimulus; each has a frame-level reference
// model feeding a scoreboard queue that an independent monitor drains on every output handshake.
module tb_product_accumulator;

  localparam int PW = 17;

  typedef struct {
    longint sum;
    bit     sat;
    int     cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic end_chk = 1'b0;
  logic [PW-1:0] in_prod = '0;

  logic [1:0]       rdy;
  logic [1:0]       ovld;
  logic [1:0]       osat;
  logic [1:0]       hold_w;
  logic [1:0][23:0] osum;
  logic [1:0][4:0]  ocnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instance 0: 18-bit sum, 16-term frames. Instance 1: 24-bit sum, 4-term frames.
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int     AW   = (g == 0) ? 18 : 24;
    localparam int     MT   = (g == 0) ? 16 : 4;
    localparam int     CW   = $clog2(MT + 1);
    localparam longint SMAX = (longint'(1) << AW) - 1;

    logic [AW-1:0] sum_i;
    logic [CW-1:0] cnt_i;

    product_accumulator #(.PROD_W(PW), .ACC_W(AW), .MAX_TERMS(MT)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (rdy[g]),
      .in_prod   (in_prod),
      .in_last   (in_last),
      .out_valid (ovld[g]),
      .out_ready (out_ready),
      .out_sum   (sum_i),
      .out_sat   (osat[g]),
      .out_count (cnt_i)
    );

    assign osum[g] = 24'(sum_i);
    assign ocnt[g] = 5'(cnt_i);

    bit     hold = 1'b0;
    longint total = 0;
    int     terms = 0;
    exp_t   q[$];

    assign hold_w[g] = hold;

    // Reference model: evaluated before each rising edge for the transfer that edge performs.
    always @(negedge clk) begin
      if (rst) begin
        if (hold) void'(q.pop_back());
        hold = 1'b0;
        total = 0;
        terms = 0;
      end else begin
        check($sformatf("out_valid%0d", g), ovld[g], hold);
        check($sformatf("in_ready%0d", g), rdy[g], !hold);
        if (flush) begin
          if (hold) void'(q.pop_back());
          hold = 1'b0;
          total = 0;
          terms = 0;
        end else if (hold) begin
          if (out_ready) hold = 1'b0;
        end else if (in_valid) begin
          total += longint'(in_prod);
          terms++;
          if (in_last || terms == MT) begin
            q.push_back('{(total > SMAX) ? SMAX : total, total > SMAX, terms});
            hold = 1'b1;
            total = 0;
            terms = 0;
          end
        end
      end
    end

    // Monitor: compares each frame handed to the consumer against the oldest expectation.
    always @(negedge clk) begin
      exp_t e;
      if (!rst && !flush && ovld[g] && out_ready) begin
        if (q.size() == 0) begin
          check($sformatf("unexpected_frame%0d", g), 1, 0);
        end else begin
          e = q.pop_front();
          check($sformatf("sb_sum%0d", g), osum[g], e.sum);
          check($sformatf("sb_sat%0d", g), osat[g], e.sat);
          check($sformatf("sb_count%0d", g), ocnt[g], e.cnt);
        end
      end
    end

    always @(posedge end_chk) begin
      check($sformatf("queue_empty%0d", g), q.size(), 0);
    end

    a_stable: assert property (@(posedge clk)
      ovld[g] && !out_ready && !flush && !rst |=>
        ovld[g] && $stable(sum_i) && $stable(cnt_i) && $stable(osat[g]));
    a_no_accept_in_hold: assert property (@(posedge clk) disable iff (rst) ovld[g] |-> !rdy[g]);
    a_count_bound: assert property (@(posedge clk) disable iff (rst) ovld[g] |-> (cnt_i <= CW'(MT)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input bit l, input int tgt);
    int n;
    in_valid = 1'b1;
    in_prod  = PW'(p);
    in_last  = l;
    n = 0;
    while (hold_w[tgt] && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("send_timeout", n, 0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    check("rst_valid", ovld[0], 0);
    check("rst_ready", rdy[0], 1);
    check("rst_sum", osum[0], 0);
    check("rst_count", ocnt[0], 0);
    check("rst_sat", osat[0], 0);
    check("rst_valid1", ovld[1], 0);

    // Three full-scale products, no saturation.
    send(65025, 0, 0); send(65025, 0, 0); send(65025, 1, 0);
    check("t1_valid", ovld[0], 1);
    check("t1_sum", osum[0], 195075);
    check("t1_count", ocnt[0], 3);
    check("t1_sat", osat[0], 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Five products into an 18-bit sum: clamps at all-ones.
    for (int i = 0; i < 5; i++) send(65025, i == 4, 0);
    check("t2_sum", osum[0], 262143);
    check("t2_sat", osat[0], 1);
    check("t2_count", ocnt[0], 5);
    drain();

    // Four-term limit closes the frame without in_last.
    for (int i = 1; i <= 4; i++) send(i, 0, 1);
    check("t3_valid", ovld[1], 1);
    check("t3_sum", osum[1], 10);
    check("t3_count", ocnt[1], 4);
    check("t3_ready", rdy[1], 0);

    // Backpressure on the held result.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_bp_valid", ovld[1], 1);
      check("t4_bp_sum", osum[1], 10);
      check("t4_bp_ready", rdy[1], 0);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("t4_rel_valid", ovld[1], 0);
    check("t4_rel_ready", rdy[1], 1);
    send(5, 1, 1);
    check("t4_fresh_sum", osum[1], 5);
    check("t4_fresh_count", ocnt[1], 1);
    drain();

    // Flush drops the product offered in the same cycle.
    send(100, 0, 0); send(200, 0, 0);
    flush = 1'b1; in_valid = 1'b1; in_prod = PW'(50); in_last = 1'b0;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_flush_valid", ovld[0], 0);
    send(7, 1, 0);
    check("t5_sum", osum[0], 7);
    check("t5_count", ocnt[0], 1);
    drain();

    // Reset while a result is held.
    send(11, 1, 0);
    check("t6_held", ovld[0], 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_valid", ovld[0], 0);
    check("t6_sum", osum[0], 0);
    check("t6_ready", rdy[0], 1);
    send(9, 1, 0);
    check("t6_sum_after", osum[0], 9);
    drain();

    // Random traffic with stalls on both sides, occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       in_prod = PW'($urandom_range(0, 255));
        1:       in_prod = 17'd65025;
        2:       in_prod = '1;
        default: in_prod = PW'($urandom);
      endcase
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; in_last = 1'b0;
    drain();
    end_chk = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
